// File: rtl/tone_generator_pkg.sv
// Shared state encoding and accumulator sizing for the tone generator.
package tone_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } state_e;

   // Accumulator must hold values up to 2*HALF == clk_hz.
   function automatic int unsigned acc_width(input int unsigned clk_hz);
      return $clog2(clk_hz + 1);
   endfunction

endpackage

// File: rtl/tone_generator_if.sv
// Control/status bundle between a tone generator and its user.
interface tone_generator_if #(
   parameter int unsigned HZ_W  = 16,
   parameter int unsigned CNT_W = 16
);
   logic             start;
   logic             stop;
   logic [HZ_W-1:0]  freq_hz;
   logic [CNT_W-1:0] burst_cycles;
   logic             tone_out;
   logic             busy;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] periods_done;

   modport master (
      output start, stop, freq_hz, burst_cycles,
      input  tone_out, busy, done, err, periods_done
   );

   modport slave (
      input  start, stop, freq_hz, burst_cycles,
      output tone_out, busy, done, err, periods_done
   );
endinterface

// File: rtl/tone_nco.sv
// Divider-free phase accumulator: adds f each enabled clock, toggles tone on crossing HALF.
module tone_nco
   import tone_gen_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned HZ_W   = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            en,
   input  logic [HZ_W-1:0] f,
   output logic            tone,
   output logic            fall_pulse
);
   localparam int unsigned Half = CLK_HZ / 2;
   localparam int unsigned AccW = acc_width(CLK_HZ);
   localparam int unsigned SumW = ((AccW > HZ_W) ? AccW : HZ_W) + 1;

   logic [AccW-1:0] acc_q, acc_d;
   logic [SumW-1:0] sum;
   logic            wrap;
   logic            tone_q;

   always_comb begin
      sum   = SumW'(acc_q) + SumW'(f);
      wrap  = (sum >= SumW'(Half));
      acc_d = wrap ? AccW'(sum - SumW'(Half)) : AccW'(sum);
   end

   // Raw "next enabled step falls"; the owner decides whether the step is enabled.
   assign fall_pulse = tone_q & wrap;
   assign tone       = tone_q;

   // clear restarts a tone: phase zero, output high.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         tone_q <= 1'b0;
      end else if (clear) begin
         acc_q  <= '0;
         tone_q <= 1'b1;
      end else if (en) begin
         acc_q <= acc_d;
         if (wrap) tone_q <= ~tone_q;
      end
   end

endmodule

// File: rtl/tone_generator.sv
// Programmable square-wave tone source: burst of N periods or continuous, graceful stop.
module tone_generator
   import tone_gen_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned HZ_W   = 16,
   parameter int unsigned CNT_W  = 16
) (
   input logic              clk,
   input logic              rst,
   tone_generator_if.slave  bus
);
   localparam int unsigned Half = CLK_HZ / 2;

   state_e           state_q, state_d;
   logic [HZ_W-1:0]  freq_q, freq_d;
   logic [CNT_W-1:0] burst_q, burst_d;
   logic [CNT_W-1:0] periods_q, periods_d, periods_inc;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             freq_ok;
   logic             nco_clear, nco_en;
   logic             tone, fall_raw, fall;

   assign freq_ok   = (bus.freq_hz != '0) && (32'(bus.freq_hz) <= Half);
   assign nco_clear = (state_q == ST_IDLE) && bus.start && freq_ok;
   // A stop seen during the low phase ends the tone before the next rise.
   assign nco_en    = ((state_q == ST_RUN) && !(bus.stop && !tone)) || (state_q == ST_DRAIN);
   assign fall      = nco_en & fall_raw;

   assign periods_inc = (periods_q == '1) ? periods_q : periods_q + 1'b1;

   tone_nco #(
      .CLK_HZ (CLK_HZ),
      .HZ_W   (HZ_W)
   ) u_nco (
      .clk        (clk),
      .rst        (rst),
      .clear      (nco_clear),
      .en         (nco_en),
      .f          (freq_q),
      .tone       (tone),
      .fall_pulse (fall_raw)
   );

   always_comb begin
      state_d   = state_q;
      freq_d    = freq_q;
      burst_d   = burst_q;
      periods_d = periods_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               if (freq_ok) begin
                  state_d   = ST_RUN;
                  freq_d    = bus.freq_hz;
                  burst_d   = bus.burst_cycles;
                  periods_d = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (bus.stop && !tone) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (fall) begin
               periods_d = periods_inc;
               // A stop coinciding with the falling edge ends here, like a burst end.
               if (bus.stop || ((burst_q != '0) && (periods_inc == burst_q))) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end else if (bus.stop) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fall) begin
               periods_d = periods_inc;
               state_d   = ST_IDLE;
               done_d    = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         freq_q    <= '0;
         burst_q   <= '0;
         periods_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         freq_q    <= freq_d;
         burst_q   <= burst_d;
         periods_q <= periods_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign bus.tone_out     = tone;
   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.done         = done_q;
   assign bus.err          = err_q;
   assign bus.periods_done = periods_q;

endmodule
